// File: rtl/ibus_sram_bank.sv
`default_nettype none
// ============================================================================
// Module   : ibus_sram_bank
// Purpose  : Instruction SRAM bank with a registered read port, byte-lane writes
//            and a clear engine that fills the array with INIT_VALUE.
// Options  : define IBUS_SRAM_PARITY_EN for per-lane even parity and error report
// Revision : 1.0 - initial release
// ============================================================================
module ibus_sram_bank #(
  parameter int          SRAM_ADDR_WIDTH = 13,
  parameter int          SRAM_DATA_WIDTH = 32,
  parameter logic [31:0] INIT_VALUE      = 32'h0000_0013,
  parameter bit          INIT_ON_RESET   = 1'b1
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       mem_cen,
  input  logic [3:0]                 mem_wen,
  input  logic [SRAM_ADDR_WIDTH-1:2] mem_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] mem_wdata,
  output logic [SRAM_DATA_WIDTH-1:0] mem_rdata,
  input  logic                       init_start,
  output logic                       init_done,
  output logic                       par_err,
  output logic [SRAM_ADDR_WIDTH-1:2] par_err_addr,
  output logic [7:0]                 par_err_cnt
);

  localparam int c_aw    = SRAM_ADDR_WIDTH - 2;
  localparam int c_depth = 1 << c_aw;
  localparam int c_lanes = SRAM_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t                     r_state;
  logic [c_aw-1:0]            r_cnt;
  logic                       r_init_done;
  logic [SRAM_DATA_WIDTH-1:0] r_rdata;
  logic [SRAM_DATA_WIDTH-1:0] r_mem [c_depth];

  logic                       w_bus_rd;
  logic                       w_bus_wr;
  logic [c_lanes-1:0]         w_we;
  logic [c_aw-1:0]            w_waddr;
  logic [SRAM_DATA_WIDTH-1:0] w_wdata;

  assign w_bus_rd = (r_state == ST_DONE) && !mem_cen && (&mem_wen);
  assign w_bus_wr = (r_state == ST_DONE) && !mem_cen && !(&mem_wen);

  // The clear engine owns the write port while clearing; bus writes are dropped.
  always_comb begin
    w_we    = '0;
    w_waddr = mem_addr;
    w_wdata = mem_wdata;
    if (r_state == ST_CLEAR) begin
      w_we    = '1;
      w_waddr = r_cnt;
      w_wdata = INIT_VALUE;
    end else if (w_bus_wr) begin
      w_we = ~mem_wen;
    end
  end

`ifdef IBUS_SRAM_PARITY_EN
  logic [c_lanes-1:0] r_par [c_depth];
`endif

  // Array storage has no reset: contents survive HRESETn.
  always_ff @(posedge HCLK) begin
    for (int l = 0; l < c_lanes; l++) begin
      if (w_we[l]) begin
        r_mem[w_waddr][8*l +: 8] <= w_wdata[8*l +: 8];
`ifdef IBUS_SRAM_PARITY_EN
        r_par[w_waddr][l] <= ^w_wdata[8*l +: 8];
`endif
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= INIT_ON_RESET ? ST_CLEAR : ST_DONE;
      r_cnt       <= '0;
      r_init_done <= !INIT_ON_RESET;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_rdata <= '0;
          r_cnt   <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state     <= ST_DONE;
            r_init_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_bus_rd) begin
            r_rdata <= r_mem[mem_addr];
          end
          // A coincident bus access has already been serviced above.
          if (init_start) begin
            r_state     <= ST_CLEAR;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

  assign mem_rdata = r_rdata;
  assign init_done = r_init_done;

`ifdef IBUS_SRAM_PARITY_EN
  logic [SRAM_DATA_WIDTH-1:0] w_rd_word;
  logic [c_lanes-1:0]         w_rd_par;
  logic [c_lanes-1:0]         w_rd_par_calc;
  logic                       r_par_err;
  logic [c_aw-1:0]            r_par_err_addr;
  logic [7:0]                 r_par_err_cnt;

  assign w_rd_word = r_mem[mem_addr];
  assign w_rd_par  = r_par[mem_addr];

  for (genvar l = 0; l < c_lanes; l++) begin : g_par_lane
    assign w_rd_par_calc[l] = ^w_rd_word[8*l +: 8];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_par_err      <= 1'b0;
      r_par_err_addr <= '0;
      r_par_err_cnt  <= '0;
    end else begin
      r_par_err <= 1'b0;
      if (w_bus_rd && (|(w_rd_par ^ w_rd_par_calc))) begin
        r_par_err      <= 1'b1;
        r_par_err_addr <= mem_addr;
        if (r_par_err_cnt != 8'hFF) begin
          r_par_err_cnt <= r_par_err_cnt + 8'd1;
        end
      end
    end
  end

  assign par_err      = r_par_err;
  assign par_err_addr = r_par_err_addr;
  assign par_err_cnt  = r_par_err_cnt;
`else
  assign par_err      = 1'b0;
  assign par_err_addr = '0;
  assign par_err_cnt  = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibus_sram_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibus_sram_bank
// Purpose  : Randomized self-checking bench for ibus_sram_bank against a
//            word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibus_sram_bank;

  localparam int          c_depth = 2048;
  localparam logic [31:0] c_init  = 32'h0000_0013;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        mem_cen;
  logic [3:0]  mem_wen;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        init_start;
  logic        init_done;
  logic        par_err;
  logic [10:0] par_err_addr;
  logic [7:0]  par_err_cnt;

  ibus_sram_bank dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .mem_cen      (mem_cen),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .init_start   (init_start),
    .init_done    (init_done),
    .par_err      (par_err),
    .par_err_addr (par_err_addr),
    .par_err_cnt  (par_err_cnt)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: word contents, lanes with corrupted parity, and outputs.
  logic [31:0] m_mem [c_depth];
  logic [3:0]  m_bad [c_depth];
  bit          m_done;
  int          m_pos;
  logic [31:0] m_rdata;
  bit          m_par_err;
  logic [10:0] m_par_addr;
  int          m_par_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_done     = 1'b0;
    m_pos      = 0;
    m_rdata    = '0;
    m_par_err  = 1'b0;
    m_par_addr = '0;
    m_par_cnt  = 0;
  endtask

  task automatic model_edge(input logic cen, input logic [3:0] wen, input logic [10:0] addr,
                            input logic [31:0] wdata, input logic start);
    m_par_err = 1'b0;
    if (m_done) begin
      if (!cen && wen == 4'hF) begin
        m_rdata = m_mem[addr];
        if (m_bad[addr] != 4'h0) begin
          m_par_err  = 1'b1;
          m_par_addr = addr;
          if (m_par_cnt < 255) m_par_cnt++;
        end
      end else if (!cen) begin
        for (int l = 0; l < 4; l++) begin
          if (!wen[l]) begin
            m_mem[addr][8*l +: 8] = wdata[8*l +: 8];
            m_bad[addr][l] = 1'b0;
          end
        end
      end
      if (start) begin
        m_done = 1'b0;
        m_pos  = 0;
      end
    end else begin
      m_mem[m_pos] = c_init;
      m_bad[m_pos] = 4'h0;
      m_rdata      = '0;
      m_pos++;
      if (m_pos == c_depth) m_done = 1'b1;
    end
  endtask

  task automatic step(input logic cen, input logic [3:0] wen, input logic [10:0] addr,
                      input logic [31:0] wdata, input logic start);
    mem_cen    = cen;
    mem_wen    = wen;
    mem_addr   = addr;
    mem_wdata  = wdata;
    init_start = start;
    @(posedge HCLK);
    model_edge(cen, wen, addr, wdata, start);
    cyc++;
    #1;
    chk("init_done", {31'd0, init_done}, {31'd0, m_done});
    chk("rdata", mem_rdata, m_rdata);
    chk("par_err", {31'd0, par_err}, {31'd0, m_par_err});
    chk("par_err_addr", {21'd0, par_err_addr}, {21'd0, m_par_addr});
    chk("par_err_cnt", {24'd0, par_err_cnt}, m_par_cnt[31:0]);
  endtask

  task automatic idle();
    step(1'b1, 4'hF, 11'd0, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [10:0] addr);
    step(1'b0, 4'hF, addr, 32'd0, 1'b0);
  endtask

  // Called only at points away from the active edge.
  task automatic do_reset();
    HRESETn    = 1'b0;
    mem_cen    = 1'b1;
    mem_wen    = 4'hF;
    mem_addr   = '0;
    mem_wdata  = '0;
    init_start = 1'b0;
    #1;
    model_reset();
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_par_err", {31'd0, par_err}, 32'd0);
    chk("rst_par_addr", {21'd0, par_err_addr}, 32'd0);
    chk("rst_par_cnt", {24'd0, par_err_cnt}, 32'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    cyc     = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < 5000) begin
      idle();
      n++;
    end
    chk(tag, cyc, 32'd2048);
  endtask

  initial begin
    for (int i = 0; i < c_depth; i++) begin
      m_mem[i] = c_init;
      m_bad[i] = 4'h0;
    end
    do_reset();

    // Bus writes and an init_start during the clear must be ignored.
    step(1'b0, 4'h0, 11'd3, 32'hAAAA_5555, 1'b0);
    step(1'b0, 4'h0, 11'd3, 32'h1234_5678, 1'b1);
    rd(11'd3);
    wait_done("t1_init_latency");
    rd(11'd0);
    chk("t1_rd_0", mem_rdata, c_init);
    rd(11'h7FF);
    chk("t1_rd_7ff", mem_rdata, c_init);
    rd(11'd3);
    chk("t3_rd_3", mem_rdata, c_init);

    step(1'b0, 4'h0, 11'd5, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 4'b1101, 11'd5, 32'h0000_1200, 1'b0);
    rd(11'd5);
    chk("t2_rd_5", mem_rdata, 32'hDEAD_12EF);
    idle();
    chk("t2_hold", mem_rdata, 32'hDEAD_12EF);

`ifdef IBUS_SRAM_PARITY_EN
    dut.r_mem[7][9] = ~dut.r_mem[7][9];
    m_mem[7][9]     = ~m_mem[7][9];
    m_bad[7][1]     = 1'b1;
    rd(11'd7);
    chk("t6_par_err", {31'd0, par_err}, 32'd1);
    chk("t6_par_addr", {21'd0, par_err_addr}, 32'd7);
    chk("t6_par_cnt", {24'd0, par_err_cnt}, 32'd1);
    chk("t6_rdata", mem_rdata, 32'h0000_0213);
    idle();
    chk("t6_pulse_end", {31'd0, par_err}, 32'd0);
    repeat (299) rd(11'd7);
    chk("t6_par_sat", {24'd0, par_err_cnt}, 32'hFF);
`endif

    step(1'b0, 4'h0, 11'd9, 32'h0BAD_F00D, 1'b0);
    step(1'b0, 4'hF, 11'd9, 32'd0, 1'b1);
    chk("t4_rd_with_start", mem_rdata, 32'h0BAD_F00D);
    chk("t4_done_low", {31'd0, init_done}, 32'd0);
    cyc = 0;
    wait_done("t4_reclear_latency");
    rd(11'd5);
    chk("t4_rd_5", mem_rdata, c_init);
    rd(11'd9);
    chk("t4_rd_9", mem_rdata, c_init);
    chk("t4_par_cnt_kept", {24'd0, par_err_cnt}, m_par_cnt[31:0]);

    step(1'b0, 4'h0, 11'd20, 32'h5555_AAAA, 1'b0);
    do_reset();
    repeat (1000) idle();
    do_reset();
    wait_done("t5_reset_mid_clear");
    rd(11'd20);
    chk("t5_rd_20", mem_rdata, c_init);

    // Random traffic concentrated on a few words to exercise overwrites.
    for (int i = 0; i < 3000; i++) begin
      logic        cen;
      logic [3:0]  wen;
      logic [10:0] addr;
      logic [31:0] wdata;
      logic        start;
      cen   = ($urandom_range(0, 3) == 0);
      wen   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom());
      addr  = ($urandom_range(0, 7) == 0) ? 11'($urandom()) : 11'($urandom_range(0, 15));
      wdata = $urandom();
      start = ($urandom_range(0, 799) == 0);
      step(cen, wen, addr, wdata, start);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
